// File: rtl/hull_fault_filter.sv
// rtl/hull_fault_filter.sv - driver fault pin synchronizer, glitch qualifier and fault latch (optional counter: HULL_FAULT_COUNT_EN)
module hull_fault_filter #(
   parameter int unsigned FILTER_LEN = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fault_n_pin,
   input  logic       clear,
   output logic       fault,
   output logic       fault_pulse,
   output logic [7:0] fault_count
);

   typedef enum logic [1:0] {
      ST_OK    = 2'd0,
      ST_QUAL  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [7:0] FLEN = 8'(FILTER_LEN);

   logic       sync1_q;
   logic       sync2_q;
   logic       sync_fault;
   state_t     state_q, state_d;
   logic [7:0] qcnt_q, qcnt_d;
   logic       fault_q, fault_d;
   logic       pulse_q, pulse_d;

   assign sync_fault = sync2_q;

   // Two-flop synchronizer on the inverted (active-high) fault pin
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= ~fault_n_pin;
         sync2_q <= sync1_q;
      end
   end

   // State, qualification counter and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_OK;
         qcnt_q  <= 8'd0;
         fault_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         fault_q <= fault_d;
         pulse_q <= pulse_d;
      end
   end

   // Next-state logic: qualify a continuous assertion, latch, release on clear once the pin is quiet
   always_comb begin
      state_d = state_q;
      qcnt_d  = qcnt_q;
      fault_d = fault_q;
      pulse_d = 1'b0;
      case (state_q)
         ST_OK: begin
            fault_d = 1'b0;
            if (sync_fault) begin
               if (FLEN == 8'd1) begin
                  state_d = ST_FAULT;
                  qcnt_d  = FLEN;
                  fault_d = 1'b1;
                  pulse_d = 1'b1;
               end else begin
                  state_d = ST_QUAL;
                  qcnt_d  = 8'd1;
               end
            end else begin
               qcnt_d = 8'd0;
            end
         end
         ST_QUAL: begin
            if (!sync_fault) begin
               state_d = ST_OK;
               qcnt_d  = 8'd0;
            end else if (qcnt_q + 8'd1 >= FLEN) begin
               state_d = ST_FAULT;
               qcnt_d  = FLEN;
               fault_d = 1'b1;
               pulse_d = 1'b1;
            end else begin
               qcnt_d = qcnt_q + 8'd1;
            end
         end
         ST_FAULT: begin
            fault_d = 1'b1;
            // Releasing while the pin is still asserted would just re-latch; hold instead
            if (clear && !sync_fault) begin
               state_d = ST_OK;
               qcnt_d  = 8'd0;
               fault_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_OK;
            qcnt_d  = 8'd0;
            fault_d = 1'b0;
         end
      endcase
   end

   assign fault       = fault_q;
   assign fault_pulse = pulse_q;

`ifdef HULL_FAULT_COUNT_EN
   logic [7:0] count_q;

   // Saturating count of latched faults, stepped alongside the pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= 8'd0;
      end else if (pulse_d && (count_q != 8'hFF)) begin
         count_q <= count_q + 8'd1;
      end
   end

   assign fault_count = count_q;
`else
   assign fault_count = 8'd0;
`endif

endmodule

// File: tb/tb_hull_fault_filter.sv
// tb/tb_hull_fault_filter.sv - directed table-driven bench for hull_fault_filter
module tb_hull_fault_filter;

`ifdef HULL_FAULT_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       fault_n_pin;
   logic       clear;
   logic       fault;
   logic       fault_pulse;
   logic [7:0] fault_count;
   logic       fault1;
   logic       pulse1;
   logic [7:0] count1;

   int n_chk;
   int n_fail;

   hull_fault_filter #(.FILTER_LEN(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .fault_n_pin (fault_n_pin),
      .clear       (clear),
      .fault       (fault),
      .fault_pulse (fault_pulse),
      .fault_count (fault_count)
   );

   hull_fault_filter #(.FILTER_LEN(1)) dut1 (
      .clk         (clk),
      .reset       (reset),
      .fault_n_pin (fault_n_pin),
      .clear       (clear),
      .fault       (fault1),
      .fault_pulse (pulse1),
      .fault_count (count1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       pin;
      logic       clr;
      logic       f;
      logic       p;
      logic [7:0] c;
   } vec_t;

   vec_t tbl[25];

   function automatic logic [7:0] ec(int v);
      if (!CNT_EN) return 8'd0;
      return (v > 255) ? 8'd255 : 8'(v);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      // Edges numbered from the first edge that samples the pin low
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
      tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
      tbl[23] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
      tbl[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd2};

      reset       = 1'b1;
      fault_n_pin = 1'b1;
      clear       = 1'b0;
      tick();
      tick();
      chk("reset_fault", {7'd0, fault}, 8'd0);
      chk("reset_pulse", {7'd0, fault_pulse}, 8'd0);
      chk("reset_count", fault_count, 8'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 25; i++) begin
         fault_n_pin = tbl[i].pin;
         clear       = tbl[i].clr;
         tick();
         chk($sformatf("vec%0d_fault", i), {7'd0, fault}, {7'd0, tbl[i].f});
         chk($sformatf("vec%0d_pulse", i), {7'd0, fault_pulse}, {7'd0, tbl[i].p});
         chk($sformatf("vec%0d_count", i), fault_count, ec(int'(tbl[i].c)));
      end
      clear = 1'b0;

      // Asynchronous reset while latched
      reset = 1'b1;
      #1;
      chk("async_rst_fault", {7'd0, fault}, 8'd0);
      chk("async_rst_count", fault_count, 8'd0);
      chk("async_rst_fault1", {7'd0, fault1}, 8'd0);
      tick();
      reset = 1'b0;

      // Pin held low from the first edge after reset
      tick();
      tick();
      chk("len1_edge2_fault", {7'd0, fault1}, 8'd0);
      tick();
      chk("len1_edge3_fault", {7'd0, fault1}, 8'd1);
      chk("len1_edge3_pulse", {7'd0, pulse1}, 8'd1);
      tick();
      chk("len1_edge4_pulse", {7'd0, pulse1}, 8'd0);
      tick();
      chk("midqual_fault", {7'd0, fault}, 8'd0);

      // Reset pulse with qcnt at 3 of 4
      reset = 1'b1;
      #1;
      chk("midqual_rst_fault", {7'd0, fault}, 8'd0);
      chk("midqual_rst_pulse", {7'd0, fault_pulse}, 8'd0);
      #2;
      reset = 1'b0;
      for (int e = 1; e <= 5; e++) tick();
      chk("restart_edge5_fault", {7'd0, fault}, 8'd0);
      tick();
      chk("restart_edge6_fault", {7'd0, fault}, 8'd1);
      chk("restart_edge6_pulse", {7'd0, fault_pulse}, 8'd1);
      chk("restart_edge6_count", fault_count, ec(1));

      fault_n_pin = 1'b1;
      tick();
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("release_fault", {7'd0, fault}, 8'd0);

      // Repeated latch/release to reach saturation
      for (int k = 0; k < 256; k++) begin
         fault_n_pin = 1'b0;
         for (int e = 0; e < 6; e++) tick();
         fault_n_pin = 1'b1;
         tick();
         tick();
         clear = 1'b1;
         tick();
         clear = 1'b0;
         chk($sformatf("sat_iter%0d_count", k), fault_count, ec(2 + k));
      end
      chk("sat_final_count", fault_count, ec(255));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
